// File: rtl/eth_udp_rx_parser_pkg.sv
`default_nettype none
// ============================================================================
// Package : eth_types_pkg
// Purpose : Shared Ethernet/IPv4/UDP receive types. Holds the parser state
//           enum, the per-frame verdict codes, protocol constants, and the
//           packed header structs that the parser captures bytes into.
// Revision: 1.0 - initial release
// ============================================================================
package eth_types_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ETH_HEADER = 3'd1,
    IP_HEADER  = 3'd2,
    UDP_HEADER = 3'd3,
    PAYLOAD    = 3'd4,
    FCS        = 3'd5,
    DISCARD    = 3'd6
  } eth_states;

  typedef enum logic [2:0] {
    ERR_OK    = 3'd0,
    ERR_MAC   = 3'd1,
    ERR_PROTO = 3'd2,
    ERR_IP    = 3'd3,
    ERR_PORT  = 3'd4,
    ERR_TRUNC = 3'd5,
    ERR_FCS   = 3'd6
  } err_code_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  // Good-frame residue in MSB-first bit order; the reflected CRC register is
  // bit-reversed before being compared against this.
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704_DD7B;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } frame_header_t;

  typedef struct packed {
    logic [7:0]  ver_ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] ident;
    logic [15:0] flags_frag;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] hdr_csum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_header_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
    logic [15:0] csum;
  } udp_header_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_udp_rx_parser_if.sv
`default_nettype none
// ============================================================================
// Interface: eth_udp_rx_parser_if
// Purpose  : Byte stream in, UDP payload stream and frame verdict out.
//   in_valid/in_data/in_last : frame bytes (dest MAC .. last FCS byte)
//   pl_valid/pl_data/pl_first/pl_last : UDP payload beats
//   frame_done/frame_ok/err_code      : end-of-frame verdict pulse
//   src_ip/src_port/payload_len       : captured header info
//   master = byte source side, slave = parser side.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_udp_rx_parser_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_first;
  logic        pl_last;
  logic        frame_done;
  logic        frame_ok;
  logic [2:0]  err_code;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [15:0] payload_len;

  modport master (
    output in_valid, in_data, in_last,
    input  pl_valid, pl_data, pl_first, pl_last,
    input  frame_done, frame_ok, err_code, src_ip, src_port, payload_len
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output pl_valid, pl_data, pl_first, pl_last,
    output frame_done, frame_ok, err_code, src_ip, src_port, payload_len
  );
endinterface
`default_nettype wire

// File: rtl/eth_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module  : eth_crc32_byte
// Purpose : Combinational one-byte update of the reflected Ethernet CRC-32
//           (poly 0x04C11DB7, processed LSB first as 0xEDB88320).
//   crc_in  [31:0] : current CRC register
//   data    [7:0]  : byte to absorb
//   crc_out [31:0] : updated CRC register
// Revision: 1.0 - initial release
// ============================================================================
module eth_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ 32'hEDB8_8320;
      else                      crc_out = crc_out >> 1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/eth_udp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module  : eth_udp_rx_parser
// Purpose : Receive-side Ethernet/IPv4/UDP parser. Walks the headers of the
//           post-SFD byte stream, filters on MAC/IP/port, streams the UDP
//           payload with first/last markers and reports a verdict per frame.
// Ports   : clk, rst_n (async, active low), io_bus (eth_udp_rx_parser_if.slave)
// Config  : ETH_RX_FCS_CHECK_EN - when defined, CRC-32 is checked at in_last
//           (err 6 on mismatch); otherwise FCS bytes are only skipped.
// Revision: 1.0 - initial release
// ============================================================================
module eth_udp_rx_parser
  import eth_types_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_udp_rx_parser_if.slave   io_bus
);

  eth_states     r_state, w_state_next;
  logic [5:0]    r_hcnt, w_hcnt_next, w_hidx, w_ip_last_idx;
  logic [15:0]   r_pcnt, w_pcnt_next;
  frame_header_t r_eth;
  ip_header_t    r_ip;
  udp_header_t   r_udp, w_udp_full;
  logic [3:0]    r_ihl;
  err_code_t     r_err, w_fail_code, w_end_code, r_err_out;
  logic          w_fail, w_emit, w_emit_first, w_emit_last, w_udp_done;
  logic          w_end, w_fcs_bad;
  logic          r_pl_valid, r_pl_first, r_pl_last, r_done, r_ok;
  logic [7:0]    r_pl_data;
  logic [31:0]   r_src_ip;
  logic [15:0]   r_src_port, r_plen;
  logic [47:0]   w_mac;

  // Byte 0 arrives while still in IDLE, so it is treated as header index 0.
  assign w_hidx        = (r_state == IDLE) ? 6'd0 : r_hcnt;
  assign w_ip_last_idx = {r_ihl, 2'b00} - 6'd1;
  assign w_end         = io_bus.in_valid & io_bus.in_last;
  assign w_mac         = {r_eth[39:0], io_bus.in_data};
  assign w_udp_full    = udp_header_t'({r_udp[55:0], io_bus.in_data});

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] r_crc, w_crc_in, w_crc_out;
  assign w_crc_in = (r_state == IDLE) ? 32'hFFFF_FFFF : r_crc;

  eth_crc32_byte u_crc (
    .crc_in  (w_crc_in),
    .data    (io_bus.in_data),
    .crc_out (w_crc_out)
  );

  assign w_fcs_bad = (bitrev32(w_crc_out) != CRC32_RESIDUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_crc <= 32'hFFFF_FFFF;
    else if (io_bus.in_valid) r_crc <= w_crc_out;
  end
`else
  assign w_fcs_bad = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_hcnt_next  = r_hcnt;
    w_pcnt_next  = r_pcnt;
    w_fail       = 1'b0;
    w_fail_code  = ERR_OK;
    w_emit       = 1'b0;
    w_emit_first = 1'b0;
    w_emit_last  = 1'b0;
    w_udp_done   = 1'b0;
    w_end_code   = ERR_OK;
    if (io_bus.in_valid) begin
      unique case (r_state)
        IDLE, ETH_HEADER: begin
          w_state_next = ETH_HEADER;
          w_hcnt_next  = w_hidx + 6'd1;
          if (w_hidx == 6'd5) begin
            if (w_mac != LOCAL_MAC && w_mac != 48'hFFFF_FFFF_FFFF) begin
              w_fail = 1'b1; w_fail_code = ERR_MAC;
            end
          end else if (w_hidx == 6'd13) begin
            if ({r_eth[7:0], io_bus.in_data} != ETHERTYPE_IPV4) begin
              w_fail = 1'b1; w_fail_code = ERR_PROTO;
            end else begin
              w_state_next = IP_HEADER; w_hcnt_next = 6'd0;
            end
          end
        end
        IP_HEADER: begin
          w_hcnt_next = r_hcnt + 6'd1;
          if (r_hcnt == 6'd0) begin
            if (io_bus.in_data[7:4] != 4'd4 || io_bus.in_data[3:0] < 4'd5) begin
              w_fail = 1'b1; w_fail_code = ERR_PROTO;
            end
          end else if (r_hcnt == 6'd9) begin
            if (io_bus.in_data != IP_PROTO_UDP) begin
              w_fail = 1'b1; w_fail_code = ERR_PROTO;
            end
          end else if (r_hcnt == 6'd19) begin
            if ({r_ip[23:0], io_bus.in_data} != LOCAL_IP) begin
              w_fail = 1'b1; w_fail_code = ERR_IP;
            end
          end
          // Options (IHL>5) are walked over without being captured.
          if (r_hcnt >= 6'd19 && r_hcnt == w_ip_last_idx) begin
            w_state_next = UDP_HEADER; w_hcnt_next = 6'd0;
          end
        end
        UDP_HEADER: begin
          w_hcnt_next = r_hcnt + 6'd1;
          if (r_hcnt == 6'd3) begin
            if (LOCAL_PORT != 16'd0 && {r_udp[7:0], io_bus.in_data} != LOCAL_PORT) begin
              w_fail = 1'b1; w_fail_code = ERR_PORT;
            end
          end else if (r_hcnt == 6'd5) begin
            if ({r_udp[7:0], io_bus.in_data} < 16'd8) begin
              w_fail = 1'b1; w_fail_code = ERR_PROTO;
            end
          end else if (r_hcnt == 6'd7) begin
            w_udp_done   = 1'b1;
            w_pcnt_next  = 16'd0;
            w_state_next = (w_udp_full.len == 16'd8) ? FCS : PAYLOAD;
          end
        end
        PAYLOAD: begin
          w_emit       = 1'b1;
          w_emit_first = (r_pcnt == 16'd0);
          w_pcnt_next  = r_pcnt + 16'd1;
          if (r_pcnt == r_plen - 16'd1) begin
            // A frame ending on its last payload byte has no FCS: truncated.
            w_emit_last  = ~io_bus.in_last;
            w_state_next = FCS;
          end
        end
        FCS, DISCARD: begin
        end
        default: w_state_next = IDLE;
      endcase
      if (w_fail) w_state_next = DISCARD;
      if (w_end) begin
        w_state_next = IDLE;
        w_hcnt_next  = 6'd0;
      end
    end
    // Priority: check on this byte, then earlier recorded failure, then
    // truncation, then FCS.
    if (w_fail)                 w_end_code = w_fail_code;
    else if (r_err != ERR_OK)   w_end_code = r_err;
    else if (r_state != FCS)    w_end_code = ERR_TRUNC;
    else if (w_fcs_bad)         w_end_code = ERR_FCS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hcnt     <= 6'd0;
      r_pcnt     <= 16'd0;
      r_eth      <= '0;
      r_ip       <= '0;
      r_udp      <= '0;
      r_ihl      <= 4'd0;
      r_err      <= ERR_OK;
      r_pl_valid <= 1'b0;
      r_pl_data  <= 8'd0;
      r_pl_first <= 1'b0;
      r_pl_last  <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_err_out  <= ERR_OK;
      r_src_ip   <= 32'd0;
      r_src_port <= 16'd0;
      r_plen     <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_hcnt  <= w_hcnt_next;
      r_pcnt  <= w_pcnt_next;
      if (io_bus.in_valid) begin
        if (r_state == IDLE || r_state == ETH_HEADER)
          r_eth <= frame_header_t'({r_eth[103:0], io_bus.in_data});
        if (r_state == IP_HEADER && r_hcnt < 6'd20)
          r_ip <= ip_header_t'({r_ip[151:0], io_bus.in_data});
        if (r_state == IP_HEADER && r_hcnt == 6'd0)
          r_ihl <= io_bus.in_data[3:0];
        if (r_state == UDP_HEADER)
          r_udp <= w_udp_full;
        if (w_end)       r_err <= ERR_OK;
        else if (w_fail) r_err <= w_fail_code;
      end
      if (w_udp_done) begin
        r_src_ip   <= r_ip.src_ip;
        r_src_port <= w_udp_full.src_port;
        r_plen     <= w_udp_full.len - 16'd8;
      end
      r_pl_valid <= w_emit;
      if (w_emit) r_pl_data <= io_bus.in_data;
      r_pl_first <= w_emit_first;
      r_pl_last  <= w_emit_last;
      r_done     <= w_end;
      r_ok       <= w_end && (w_end_code == ERR_OK);
      r_err_out  <= w_end ? w_end_code : ERR_OK;
    end
  end

  // Header fields kept for visibility but not used by any check.
  logic w_unused;
  assign w_unused = ^{r_eth, r_ip, r_udp, w_udp_full};

  assign io_bus.pl_valid    = r_pl_valid;
  assign io_bus.pl_data     = r_pl_data;
  assign io_bus.pl_first    = r_pl_first;
  assign io_bus.pl_last     = r_pl_last;
  assign io_bus.frame_done  = r_done;
  assign io_bus.frame_ok    = r_ok;
  assign io_bus.err_code    = r_err_out;
  assign io_bus.src_ip      = r_src_ip;
  assign io_bus.src_port    = r_src_port;
  assign io_bus.payload_len = r_plen;

endmodule
`default_nettype wire

// File: tb/tb_eth_udp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_udp_rx_parser
// Purpose : Self-checking bench for eth_udp_rx_parser. Two instances share
//           one input stream: dut0 filters on port 5000, dut1 accepts any port.
//           Frames are built from a vector table; payload beats and verdicts
//           are queued as stimulus is driven and checked by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_udp_rx_parser;

  localparam logic [47:0] C_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] C_IP   = 32'hC0A8_0164;
  localparam logic [31:0] C_SIP  = 32'hC0A8_010A;
  localparam logic [15:0] C_SPRT = 16'd1234;
`ifdef ETH_RX_FCS_CHECK_EN
  localparam logic [2:0]  C_FLIP_ERR = 3'd6;
`else
  localparam logic [2:0]  C_FLIP_ERR = 3'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_udp_rx_parser_if bus0 ();
  eth_udp_rx_parser_if bus1 ();

  assign bus1.in_valid = bus0.in_valid;
  assign bus1.in_data  = bus0.in_data;
  assign bus1.in_last  = bus0.in_last;

  eth_udp_rx_parser #(.LOCAL_MAC(C_MAC), .LOCAL_IP(C_IP), .LOCAL_PORT(16'd5000)) dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus0));
  eth_udp_rx_parser #(.LOCAL_MAC(C_MAC), .LOCAL_IP(C_IP), .LOCAL_PORT(16'd0)) dut1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1));

  typedef struct {
    string       name;
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [31:0] dip;
    logic [15:0] dport;
    int          plen;
    int          ulen;      // -1: plen+8
    int          ihl;
    int          trunc_at;  // -1: full frame
    int          flip;      // -1: none, else payload byte index
    bit          gaps;
    logic [2:0]  exp_err0;
    logic [2:0]  exp_err1;
  } vec_t;

  typedef struct packed {
    logic [2:0]  err;
    logic        ok;
    logic        info;
    logic [15:0] plen;
  } verd_t;

  vec_t        vecs[$];
  logic [7:0]  fq[$];
  int          pl_start;
  logic [9:0]  exp_pl[$];
  verd_t       vq0[$];
  verd_t       vq1[$];
  int          checks = 0;
  int          fails  = 0;

  function automatic vec_t mk(string name, logic [47:0] dmac, logic [15:0] et,
                              logic [7:0] pr, logic [31:0] dip, logic [15:0] dp,
                              int plen, int ulen, int ihl, int trunc, int flip,
                              bit gaps, logic [2:0] e0, logic [2:0] e1);
    vec_t v;
    v.name = name; v.dmac = dmac; v.etype = et; v.proto = pr; v.dip = dip;
    v.dport = dp; v.plen = plen; v.ulen = ulen; v.ihl = ihl; v.trunc_at = trunc;
    v.flip = flip; v.gaps = gaps; v.exp_err0 = e0; v.exp_err1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push16(input logic [15:0] v);
    fq.push_back(v[15:8]);
    fq.push_back(v[7:0]);
  endtask

  task automatic build_frame(input vec_t v);
    logic [31:0] crc;
    logic [15:0] ulen, tlen;
    logic [7:0]  b;
    fq.delete();
    for (int i = 5; i >= 0; i--) fq.push_back(v.dmac[8*i +: 8]);
    push16(16'h0200); push16(16'h0000); push16(16'h00AA);
    push16(v.etype);
    ulen = (v.ulen >= 0) ? 16'(v.ulen) : 16'(v.plen + 8);
    tlen = 16'(v.ihl * 4) + ulen;
    b = {4'h4, 4'(v.ihl)};
    fq.push_back(b); fq.push_back(8'h00);
    push16(tlen); push16(16'h0000); push16(16'h4000);
    fq.push_back(8'h40); fq.push_back(v.proto);
    push16(16'h0000);
    push16(C_SIP[31:16]); push16(C_SIP[15:0]);
    push16(v.dip[31:16]); push16(v.dip[15:0]);
    for (int i = 0; i < (v.ihl - 5) * 4; i++) fq.push_back(8'h00);
    push16(C_SPRT); push16(v.dport); push16(ulen); push16(16'h0000);
    pl_start = fq.size();
    for (int i = 0; i < v.plen; i++) fq.push_back(8'(i));
    while (fq.size() < 60) fq.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (fq[k]) begin
      crc = crc ^ {24'd0, fq[k]};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) fq.push_back(crc[8*i +: 8]);
    if (v.flip >= 0) fq[pl_start + v.flip] = fq[pl_start + v.flip] ^ 8'h01;
    if (v.trunc_at >= 0) while (fq.size() > v.trunc_at + 1) void'(fq.pop_back());
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((vq0.size() != 0 || vq1.size() != 0 || exp_pl.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_pending"}, 64'(vq0.size() + vq1.size() + exp_pl.size()), 64'd0);
  endtask

  task automatic drive_frame(input vec_t v, input int nbytes, input bit with_last);
    bit    stream;
    verd_t ve;
    stream = (v.exp_err0 == 3'd0) || (v.exp_err0 == 3'd6);
    for (int k = 0; k < nbytes; k++) begin
      if (v.gaps && (k % 7 == 3)) begin
        @(posedge clk); #1;
        bus0.in_valid = 1'b0; bus0.in_last = 1'b0;
      end
      @(posedge clk); #1;
      bus0.in_valid = 1'b1;
      bus0.in_data  = fq[k];
      bus0.in_last  = with_last && (k == nbytes - 1);
      if (stream && k >= pl_start && k < pl_start + v.plen)
        exp_pl.push_back({fq[k], (k == pl_start), (k == pl_start + v.plen - 1)});
      if (with_last && k == nbytes - 1) begin
        ve.err = v.exp_err0; ve.ok = (v.exp_err0 == 3'd0);
        ve.info = ve.ok; ve.plen = 16'(v.plen);
        vq0.push_back(ve);
        ve.err = v.exp_err1; ve.ok = (v.exp_err1 == 3'd0); ve.info = 1'b0;
        vq1.push_back(ve);
      end
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  task automatic monitor();
    logic [9:0] e;
    verd_t      ve;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus0.pl_valid) begin
          if (exp_pl.size() == 0) begin
            checks++; fails++;
            $display("FAIL pl_unexpected data=%0h first=%0b last=%0b required=none",
                     bus0.pl_data, bus0.pl_first, bus0.pl_last);
          end else begin
            e = exp_pl.pop_front();
            chk("pl_beat{data,first,last}", {54'd0, bus0.pl_data, bus0.pl_first, bus0.pl_last}, {54'd0, e});
          end
        end
        if (bus0.frame_done) begin
          if (vq0.size() == 0) begin
            checks++; fails++;
            $display("FAIL verdict0_unexpected err=%0d required=none", bus0.err_code);
          end else begin
            ve = vq0.pop_front();
            chk("err_code0", 64'(bus0.err_code), 64'(ve.err));
            chk("frame_ok0", 64'(bus0.frame_ok), 64'(ve.ok));
            if (ve.info) begin
              chk("src_ip", 64'(bus0.src_ip), 64'(C_SIP));
              chk("src_port", 64'(bus0.src_port), 64'(C_SPRT));
              chk("payload_len", 64'(bus0.payload_len), 64'(ve.plen));
            end
          end
        end
        if (bus1.frame_done) begin
          if (vq1.size() == 0) begin
            checks++; fails++;
            $display("FAIL verdict1_unexpected err=%0d required=none", bus1.err_code);
          end else begin
            ve = vq1.pop_front();
            chk("err_code1", 64'(bus1.err_code), 64'(ve.err));
            chk("frame_ok1", 64'(bus1.frame_ok), 64'(ve.ok));
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pl_valid"},    64'(bus0.pl_valid),    64'd0);
    chk({tag, "_pl_first"},    64'(bus0.pl_first),    64'd0);
    chk({tag, "_pl_last"},     64'(bus0.pl_last),     64'd0);
    chk({tag, "_pl_data"},     64'(bus0.pl_data),     64'd0);
    chk({tag, "_frame_done"},  64'(bus0.frame_done),  64'd0);
    chk({tag, "_frame_ok"},    64'(bus0.frame_ok),    64'd0);
    chk({tag, "_err_code"},    64'(bus0.err_code),    64'd0);
    chk({tag, "_src_ip"},      64'(bus0.src_ip),      64'd0);
    chk({tag, "_src_port"},    64'(bus0.src_port),    64'd0);
    chk({tag, "_payload_len"}, 64'(bus0.payload_len), 64'd0);
  endtask

  initial begin
    int dn;
    vec_t g;
    bus0.in_valid = 1'b0;
    bus0.in_data  = 8'h00;
    bus0.in_last  = 1'b0;

    //        name        dmac              etype     pr     dip            dport  plen ulen ihl trunc flip gaps e0  e1
    vecs.push_back(mk("good18",  C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000, 18, -1, 5, -1, -1, 0, 3'd0, 3'd0));
    vecs.push_back(mk("pad4",    C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000,  4, -1, 5, -1, -1, 1, 3'd0, 3'd0));
    vecs.push_back(mk("badmac",  48'h020000000002, 16'h0800, 8'd17, C_IP,          16'd5000,  8, -1, 5, -1, -1, 0, 3'd1, 3'd1));
    vecs.push_back(mk("bcast",   48'hFFFFFFFFFFFF, 16'h0800, 8'd17, C_IP,          16'd5000,  6, -1, 5, -1, -1, 0, 3'd0, 3'd0));
    vecs.push_back(mk("arp",     C_MAC,            16'h0806, 8'd17, C_IP,          16'd5000,  6, -1, 5, -1, -1, 0, 3'd2, 3'd2));
    vecs.push_back(mk("tcp",     C_MAC,            16'h0800, 8'd6,  C_IP,          16'd5000,  6, -1, 5, -1, -1, 0, 3'd2, 3'd2));
    vecs.push_back(mk("port5001",C_MAC,            16'h0800, 8'd17, C_IP,          16'd5001,  6, -1, 5, -1, -1, 0, 3'd4, 3'd0));
    vecs.push_back(mk("badip",   C_MAC,            16'h0800, 8'd17, 32'hC0A80165,  16'd5000,  6, -1, 5, -1, -1, 0, 3'd3, 3'd3));
    vecs.push_back(mk("trunc",   C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000, 18, -1, 5, 37, -1, 0, 3'd5, 3'd5));
    vecs.push_back(mk("ipopt",   C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000,  5, -1, 6, -1, -1, 1, 3'd0, 3'd0));
    vecs.push_back(mk("udplen4", C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000,  0,  4, 5, -1, -1, 0, 3'd2, 3'd2));
    vecs.push_back(mk("plen0",   C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000,  0, -1, 5, -1, -1, 0, 3'd0, 3'd0));
    vecs.push_back(mk("plen1",   C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000,  1, -1, 5, -1, -1, 0, 3'd0, 3'd0));
    vecs.push_back(mk("fcsflip", C_MAC,            16'h0800, 8'd17, C_IP,          16'd5000, 18, -1, 5, -1,  3, 0, C_FLIP_ERR, C_FLIP_ERR));

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      build_frame(vecs[i]);
      drive_frame(vecs[i], fq.size(), 1'b1);
      wait_drain(vecs[i].name);
      repeat (2) @(posedge clk);
    end

    // Reset in the middle of the payload: abort with no verdict, then resync.
    g = vecs[0];
    build_frame(g);
    drive_frame(g, pl_start + 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midreset_beats_pending", 64'(exp_pl.size()), 64'd0);
    #1 rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.frame_done || bus1.frame_done) dn++;
    end
    chk("midreset_no_frame_done", 64'(dn), 64'd0);
    build_frame(g);
    drive_frame(g, fq.size(), 1'b1);
    wait_drain("resync");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
